io_bus_sequencer: RTL and testbench
===================================

// Module: io_bus_sequencer
// PURPOSE
// Two-port bus master that sequences peripheral accesses on the shared sysbus.
// Each access drives the MAR/MDR/CS/R_NW/MDR_bus control set for memory-mapped
// peripherals, e.g. the switch/segment register: switches at address 30, hex display at 31.
// Arbitrates round-robin between requester 0 (CPU side) and requester 1 (background poller).
// Returns read data and a one-cycle done pulse to the granted requester.
// PARAMETERS
// WORD_W    8  sysbus / data width
// OP_W      3  opcode field width; address width is ADDR_W = WORD_W-OP_W
// EXEC_CYC  1  cycles CS held in EXEC, range 1..15
// PORTS
// clock      in     1        system clock, rising edge
// n_reset    in     1        asynchronous, active-low reset
// req        in     2        access request per requester, held high until done
// wr         in     2        1 = write, 0 = read; sampled with req
// addr0      in     ADDR_W   requester 0 peripheral address
// addr1      in     ADDR_W   requester 1 peripheral address
// wdata0     in     WORD_W   requester 0 write data
// wdata1     in     WORD_W   requester 1 write data
// done       out    2        one-cycle completion pulse to the granted requester
// rdata      out    WORD_W   last read result, valid from the done cycle
// busy       out    1        high whenever state != IDLE
// load_MAR   out    1        peripheral MAR load strobe
// load_MDR   out    1        peripheral MDR load strobe
// CS         out    1        peripheral chip select
// R_NW       out    1        1 = read, 0 = write; qualified by CS
// MDR_bus    out    1        peripheral drives sysbus
// sysbus     inout  WORD_W   shared bus; Z unless in ADDR or DATA
// BEHAVIOUR
// Reset values:
// - state=IDLE, done=0, rdata=0, busy=0, strobes 0, R_NW=1, sysbus=Z.
// - rr pointer=0, so requester 0 has priority first.
// Grant in IDLE:
// - Grant when any req is high.
// - Both high: grant requester rr. Otherwise grant the single requester.
// - Latch g, wr[g], addr_g, wdata_g into internal regs.
// States (one cycle each unless noted):
// - IDLE: wait for a request, grant as above.
// - ADDR: sysbus={OP_W'b0,addr}, load_MAR=1. Next: DATA if write, else EXEC.
// - DATA: sysbus=wdata, load_MDR=1. Next: EXEC.
// - EXEC: CS=1, R_NW=~wr for EXEC_CYC cycles (4-bit down-counter). Next: DONE if write, else READ.
// - READ: MDR_bus=1, sysbus Z; rdata<=sysbus on this edge. Next: DONE.
// - DONE: done[g]=1, rr<=~g. Next: IDLE.
// Latency and throughput:
// - Accept edge to done: write 3+EXEC_CYC cycles, read 3+EXEC_CYC cycles.
// - Back-to-back grants separated by one IDLE cycle.
// Strobes:
// - Mutually exclusive. R_NW=1 outside EXEC.
// - Never drive sysbus while MDR_bus=1.
// Request handling:
// - req dropped mid-transaction: transaction completes, done still pulses.
// - Latched operands are unaffected by input changes after grant.
// - A requester holding req after done is re-eligible only after the other has been served, if pending.
// Async reset mid-transaction: immediate return to reset values; no done pulse; peripheral state is not rolled back.
// Out-of-range EXEC_CYC: EXEC_CYC=0 treated as 1.
// TESTING
// T1 reset: n_reset low mid-EXEC -> CS=0, sysbus=Z, busy=0, no done pulse.
// T2 write 0xA5 to addr 31 (req=01, wr=01):
//    -> ADDR sysbus=0x1F; DATA sysbus=0xA5; EXEC CS=1 R_NW=0.
//    -> SSR hex1=0xA5; done[0] pulses 4 cycles after the accept edge.
// T3 read addr 30 with switches=0x3C -> READ MDR_bus=1; rdata=0x3C; done[0] pulses 1 cycle.
// T4 req=11 held continuously, both read -> grant order 0,1,0,1; each done exactly one pulse.
// T5 EXEC_CYC=3, write 0x0F to addr 31 -> CS high exactly 3 cycles; done after 6 cycles.
// T6 req[1] dropped during ADDR -> transaction completes, done[1] pulses, next grant from IDLE.

Source files
------------

// File: rtl/io_bus_sequencer_if.sv
// rtl/io_bus_sequencer_if.sv - requester handshake and peripheral strobe bundle for io_bus_sequencer
//
// Purpose: groups the two-requester handshake and the peripheral control
// strobes of the sysbus sequencer. The tri-state sysbus itself stays a plain
// inout port on the sequencer.
// Signals:
//   req[1:0], wr[1:0]        per-requester request / write flag
//   addr0, addr1             per-requester peripheral address (ADDR_W)
//   wdata0, wdata1           per-requester write data (WORD_W)
//   done[1:0]                one-cycle completion pulse to the granted requester
//   rdata                    last read result
//   busy                     sequencer not idle
//   load_MAR, load_MDR, CS, R_NW, MDR_bus   peripheral control set
// Modports: master = requester/peripheral side, slave = sequencer side.
interface io_bus_sequencer_if #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
);
  localparam int ADDR_W = WORD_W - OP_W;

  logic [1:0]        req;
  logic [1:0]        wr;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [WORD_W-1:0] wdata0;
  logic [WORD_W-1:0] wdata1;
  logic [1:0]        done;
  logic [WORD_W-1:0] rdata;
  logic              busy;
  logic              load_MAR;
  logic              load_MDR;
  logic              CS;
  logic              R_NW;
  logic              MDR_bus;

  modport master (
    output req, wr, addr0, addr1, wdata0, wdata1,
    input  done, rdata, busy, load_MAR, load_MDR, CS, R_NW, MDR_bus
  );

  modport slave (
    input  req, wr, addr0, addr1, wdata0, wdata1,
    output done, rdata, busy, load_MAR, load_MDR, CS, R_NW, MDR_bus
  );
endinterface

// File: rtl/io_bus_sequencer.sv
// rtl/io_bus_sequencer.sv - two-requester round-robin sysbus access sequencer
//
// Purpose: grants one of two requesters, then walks the peripheral through
// ADDR -> (DATA) -> EXEC -> (READ) -> DONE using the MAR/MDR/CS/R_NW/MDR_bus
// control set on the shared tri-state sysbus.
// Ports:
//   clock      in     rising-edge clock
//   n_reset    in     asynchronous active-low reset
//   bus        slave  io_bus_sequencer_if (handshake + peripheral strobes)
//   sysbus     inout  shared bus, driven only in ADDR and DATA
module io_bus_sequencer #(
  parameter int WORD_W   = 8,
  parameter int OP_W     = 3,
  parameter int EXEC_CYC = 1
) (
  input  logic                clock,
  input  logic                n_reset,
  io_bus_sequencer_if.slave   bus,
  inout  wire  [WORD_W-1:0]   sysbus
);
  localparam int ADDR_W = WORD_W - OP_W;
  // EXEC length held in a 4-bit counter; 0 behaves as 1, larger values clamp.
  localparam logic [3:0] EXEC_LEN = (EXEC_CYC < 1)  ? 4'd1  :
                                    (EXEC_CYC > 15) ? 4'd15 : 4'(EXEC_CYC);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_EXEC = 3'd3,
    S_READ = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              g_q, g_d;
  logic              wr_q, wr_d;
  logic              rr_q, rr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [3:0]        cnt_q, cnt_d;

  logic              drive_en;
  logic [WORD_W-1:0] bus_out;
  logic [1:0]        done_c;
  logic              load_mar_c, load_mdr_c, cs_c, r_nw_c, mdr_bus_c;
  logic              g_sel;

  // Both requesting: the round-robin pointer decides; otherwise the lone requester.
  assign g_sel = (bus.req == 2'b11) ? rr_q : bus.req[1];

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      g_q     <= 1'b0;
      wr_q    <= 1'b0;
      rr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      wr_q    <= wr_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    wr_d       = wr_q;
    rr_d       = rr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    drive_en   = 1'b0;
    bus_out    = '0;
    done_c     = 2'b00;
    load_mar_c = 1'b0;
    load_mdr_c = 1'b0;
    cs_c       = 1'b0;
    r_nw_c     = 1'b1;
    mdr_bus_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req != 2'b00) begin
          g_d     = g_sel;
          wr_d    = bus.wr[g_sel];
          addr_d  = g_sel ? bus.addr1 : bus.addr0;
          wdata_d = g_sel ? bus.wdata1 : bus.wdata0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        drive_en   = 1'b1;
        bus_out    = {{OP_W{1'b0}}, addr_q};
        load_mar_c = 1'b1;
        cnt_d      = EXEC_LEN;
        state_d    = wr_q ? S_DATA : S_EXEC;
      end
      S_DATA: begin
        drive_en   = 1'b1;
        bus_out    = wdata_q;
        load_mdr_c = 1'b1;
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        cs_c   = 1'b1;
        r_nw_c = ~wr_q;
        if (cnt_q <= 4'd1) begin
          state_d = wr_q ? S_DONE : S_READ;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_READ: begin
        // The peripheral owns sysbus here; we only sample it.
        mdr_bus_c = 1'b1;
        rdata_d   = sysbus;
        state_d   = S_DONE;
      end
      S_DONE: begin
        done_c  = g_q ? 2'b10 : 2'b01;
        rr_d    = ~g_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sysbus       = drive_en ? bus_out : {WORD_W{1'bz}};
  assign bus.done     = done_c;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.load_MAR = load_mar_c;
  assign bus.load_MDR = load_mdr_c;
  assign bus.CS       = cs_c;
  assign bus.R_NW     = r_nw_c;
  assign bus.MDR_bus  = mdr_bus_c;
endmodule

// File: tb/tb_io_bus_sequencer.sv
// tb/tb_io_bus_sequencer.sv - randomized self-checking bench for io_bus_sequencer
module tb_io_bus_sequencer;
  localparam int E    = 1;
  localparam int TLEN = 3 + E;

  logic clock = 1'b0;
  logic n_reset;
  always #5 clock = ~clock;

  io_bus_sequencer_if #(.WORD_W(8), .OP_W(3)) bus1();
  io_bus_sequencer_if #(.WORD_W(8), .OP_W(3)) bus3();
  wire [7:0] sysbus1;
  wire [7:0] sysbus3;

  io_bus_sequencer #(.WORD_W(8), .OP_W(3), .EXEC_CYC(E)) dut1 (
    .clock(clock), .n_reset(n_reset), .bus(bus1.slave), .sysbus(sysbus1)
  );
  io_bus_sequencer #(.WORD_W(8), .OP_W(3), .EXEC_CYC(3)) dut3 (
    .clock(clock), .n_reset(n_reset), .bus(bus3.slave), .sysbus(sysbus3)
  );

  // Peripheral: MAR/MDR registers and a 32-entry register file
  // (30 = switches, 31 = hex display).
  function automatic logic [7:0] init_val(input int i);
    return (i == 30) ? 8'h3C : 8'(i * 37 + 11);
  endfunction

  logic [7:0] pmem [32];
  logic [4:0] p_mar;
  logic [7:0] p_mdr;
  bit         p_ready = 1'b0;

  always @(posedge clock) begin
    if (!p_ready) begin
      for (int i = 0; i < 32; i++) pmem[i] <= init_val(i);
      p_ready <= 1'b1;
    end else begin
      if (bus1.load_MAR) p_mar <= sysbus1[4:0];
      if (bus1.load_MDR) p_mdr <= sysbus1;
      if (bus1.CS && !bus1.R_NW) pmem[p_mar] <= p_mdr;
    end
  end
  assign sysbus1 = bus1.MDR_bus ? pmem[p_mar] : 8'bz;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: an access occupies TLEN cycles after grant,
  // counted down in m_cnt; position within the window gives the strobes.
  int         m_cnt;
  bit         m_g, m_wr, m_rr;
  logic [4:0] m_addr;
  logic [7:0] m_wdata, m_rdata;
  logic [7:0] exp_mem [32];
  bit         active [2];
  bit         rnd_en;

  task automatic model_reset();
    m_cnt = 0; m_rr = 1'b0; m_rdata = 8'h00; m_g = 1'b0; m_wr = 1'b0;
  endtask

  task automatic model_edge();
    if (m_cnt == 0) begin
      if (bus1.req != 2'b00) begin
        m_g     = (bus1.req == 2'b11) ? m_rr : bus1.req[1];
        m_wr    = bus1.wr[m_g];
        m_addr  = m_g ? bus1.addr1 : bus1.addr0;
        m_wdata = m_g ? bus1.wdata1 : bus1.wdata0;
        m_cnt   = TLEN;
      end
    end else begin
      if (m_cnt == 2) begin
        if (m_wr) exp_mem[m_addr] = m_wdata;
        else      m_rdata = exp_mem[m_addr];
      end
      if (m_cnt == 1) m_rr = !m_g;
      m_cnt--;
    end
  endtask

  task automatic check_outputs();
    logic [1:0] e_done;
    bit e_mar, e_mdr, e_cs, e_rnw, e_mbus;
    e_done = (m_cnt == 1) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
    e_mar  = (m_cnt == TLEN);
    e_mdr  = m_wr && (m_cnt == TLEN - 1);
    e_cs   = m_wr ? (m_cnt >= 2 && m_cnt <= TLEN - 2) : (m_cnt >= 3 && m_cnt <= TLEN - 1);
    e_mbus = !m_wr && (m_cnt == 2);
    e_rnw  = e_cs ? !m_wr : 1'b1;
    check("busy", 32'(bus1.busy), 32'(m_cnt != 0));
    check("done", 32'(bus1.done), 32'(e_done));
    check("rdata", 32'(bus1.rdata), 32'(m_rdata));
    check("strobes", 32'({bus1.load_MAR, bus1.load_MDR, bus1.CS, bus1.R_NW, bus1.MDR_bus}),
          32'({e_mar, e_mdr, e_cs, e_rnw, e_mbus}));
    if (e_mar) check("bus_addr", 32'(sysbus1), 32'({3'b000, m_addr}));
    if (e_mdr) check("bus_wdata", 32'(sysbus1), 32'(m_wdata));
    if (m_cnt == 1 && m_wr) check("periph_mem", 32'(pmem[m_addr]), 32'(m_wdata));
  endtask

  task automatic set_ops(input int r, input bit w, input logic [4:0] a, input logic [7:0] d);
    bus1.wr[r] = w;
    if (r == 0) begin bus1.addr0 = a; bus1.wdata0 = d; end
    else        begin bus1.addr1 = a; bus1.wdata1 = d; end
  endtask

  function automatic logic [4:0] pick_addr();
    int s;
    s = $urandom_range(3, 0);
    return (s == 0) ? 5'd30 : (s == 1) ? 5'd31 : 5'($urandom);
  endfunction

  task automatic new_txn(input int r);
    bus1.req[r] = 1'b1;
    set_ops(r, 1'($urandom), pick_addr(), 8'($urandom));
    active[r] = 1'b1;
  endtask

  task automatic drive_random();
    for (int r = 0; r < 2; r++) begin
      if (m_cnt == 1 && m_g == 1'(r)) begin
        active[r] = 1'b0;
        if ($urandom_range(1, 0) == 1) new_txn(r);
        else bus1.req[r] = 1'b0;
      end else if (!active[r]) begin
        if ($urandom_range(2, 0) == 0) new_txn(r);
      end else if (m_cnt != 0 && m_g == 1'(r)) begin
        // After grant: operand churn and early req drop must not disturb the access.
        if ($urandom_range(3, 0) == 0) set_ops(r, 1'($urandom), 5'($urandom), 8'($urandom));
        if ($urandom_range(7, 0) == 0) bus1.req[r] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    if (n_reset) model_edge();
    @(negedge clock);
    check_outputs();
    if (rnd_en) drive_random();
  endtask

  task automatic directed(input string tag, input int r, input bit w, input logic [4:0] a,
                          input logic [7:0] d);
    int k;
    bus1.req[r] = 1'b1;
    set_ops(r, w, a, d);
    for (k = 1; k <= 30; k++) begin
      step();
      if (bus1.done[r]) break;
    end
    check({tag, "_lat"}, 32'(k), 32'(TLEN));
    bus1.req[r] = 1'b0;
  endtask

  initial begin
    int ndone, k, cs_cnt, done_at, pulses;
    logic [1:0] order [4];
    n_reset = 1'b0;
    rnd_en  = 1'b0;
    bus1.req = 2'b00; bus1.wr = 2'b00; bus1.addr0 = '0; bus1.addr1 = '0;
    bus1.wdata0 = '0; bus1.wdata1 = '0;
    bus3.req = 2'b00; bus3.wr = 2'b00; bus3.addr0 = '0; bus3.addr1 = '0;
    bus3.wdata0 = '0; bus3.wdata1 = '0;
    active[0] = 1'b0; active[1] = 1'b0;
    for (int i = 0; i < 32; i++) exp_mem[i] = init_val(i);
    model_reset();
    repeat (3) @(negedge clock);
    check_outputs();
    n_reset = 1'b1;

    // T1: async reset in the middle of EXEC of a read.
    bus1.req[0] = 1'b1;
    set_ops(0, 1'b0, 5'd30, 8'h00);
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_cnt == TLEN - 1) break;
    end
    check("t1_cs_before", 32'(bus1.CS), 32'd1);
    #2 n_reset = 1'b0;
    #1;
    check("t1_cs", 32'(bus1.CS), 32'd0);
    check("t1_busy", 32'(bus1.busy), 32'd0);
    check("t1_done", 32'(bus1.done), 32'd0);
    check("t1_rnw", 32'(bus1.R_NW), 32'd1);
    check("t1_mdrbus", 32'(bus1.MDR_bus), 32'd0);
    model_reset();
    bus1.req = 2'b00;
    @(negedge clock);
    @(negedge clock);
    n_reset = 1'b1;

    // T4: both requesters reading, req held throughout.
    bus1.req = 2'b11;
    set_ops(0, 1'b0, 5'd30, 8'h00);
    set_ops(1, 1'b0, 5'd31, 8'h00);
    ndone = 0;
    for (int i = 0; i < 60 && ndone < 4; i++) begin
      step();
      if (bus1.done != 2'b00) begin
        order[ndone] = bus1.done;
        ndone++;
      end
    end
    bus1.req = 2'b00;
    check("t4_count", 32'(ndone), 32'd4);
    for (int i = 0; i < ndone; i++)
      check("t4_order", 32'(order[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
    step();

    // T2 / T3: hex write, then switch read.
    directed("t2", 0, 1'b1, 5'd31, 8'hA5);
    check("t2_hex", 32'(pmem[31]), 32'hA5);
    step();
    directed("t3", 0, 1'b0, 5'd30, 8'h00);
    check("t3_rdata", 32'(bus1.rdata), 32'h3C);
    step();

    // Randomized traffic including T6-style early req drop.
    rnd_en = 1'b1;
    repeat (3000) step();
    rnd_en = 1'b0;
    bus1.req = 2'b00;

    // T5: EXEC_CYC=3 instance, write 0x0F to address 31.
    @(negedge clock);
    bus3.req = 2'b01; bus3.wr = 2'b01; bus3.addr0 = 5'd31; bus3.wdata0 = 8'h0F;
    cs_cnt = 0; done_at = 0; pulses = 0;
    for (k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (bus3.load_MAR) check("t5_addr", 32'(sysbus3), 32'h1F);
      if (bus3.load_MDR) check("t5_data", 32'(sysbus3), 32'h0F);
      if (bus3.CS) begin
        cs_cnt++;
        check("t5_rnw", 32'(bus3.R_NW), 32'd0);
      end
      if (bus3.done != 2'b00) begin
        pulses++;
        if (done_at == 0) done_at = k;
        check("t5_done_port", 32'(bus3.done), 32'h1);
        bus3.req = 2'b00;
      end
    end
    check("t5_cs_cycles", 32'(cs_cnt), 32'd3);
    check("t5_done_lat", 32'(done_at), 32'd6);
    check("t5_done_pulses", 32'(pulses), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
